ofs_plat_local_mem_axi_wr_burst_splitter: RTL



---
 rtl/ofs_plat_local_mem_axi_wr_burst_splitter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ofs_plat_local_mem_axi_wr_burst_splitter.sv
// Splits AFU write bursts into FIU bursts of at most FIU_MAX_BURST beats and squashes all but the final B.
// Define LM_AXI_B_RESP_MERGE_EN to fold squashed B responses into the response returned to the AFU.
module ofs_plat_local_mem_axi_wr_burst_splitter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = 8,
    parameter int USER_WIDTH     = 4,
    parameter int AFU_LEN_WIDTH  = 8,
    parameter int FIU_MAX_BURST  = 16,
    parameter int LEN_FIFO_DEPTH = 4,
    localparam int DATA_BYTES    = DATA_WIDTH / 8,
    localparam int FIU_LEN_WIDTH = (FIU_MAX_BURST > 1) ? $clog2(FIU_MAX_BURST) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     afu_aw_valid,
    output logic                     afu_aw_ready,
    input  logic [ID_WIDTH-1:0]      afu_aw_id,
    input  logic [ADDR_WIDTH-1:0]    afu_aw_addr,
    input  logic [AFU_LEN_WIDTH-1:0] afu_aw_len,
    input  logic [USER_WIDTH-1:0]    afu_aw_user,

    output logic                     fiu_aw_valid,
    input  logic                     fiu_aw_ready,
    output logic [ID_WIDTH-1:0]      fiu_aw_id,
    output logic [ADDR_WIDTH-1:0]    fiu_aw_addr,
    output logic [FIU_LEN_WIDTH-1:0] fiu_aw_len,
    output logic [USER_WIDTH-1:0]    fiu_aw_user,

    input  logic                     afu_w_valid,
    output logic                     afu_w_ready,
    input  logic [DATA_WIDTH-1:0]    afu_w_data,
    input  logic [DATA_BYTES-1:0]    afu_w_strb,
    input  logic                     afu_w_last,

    output logic                     fiu_w_valid,
    input  logic                     fiu_w_ready,
    output logic [DATA_WIDTH-1:0]    fiu_w_data,
    output logic [DATA_BYTES-1:0]    fiu_w_strb,
    output logic                     fiu_w_last,

    input  logic                     fiu_b_valid,
    output logic                     fiu_b_ready,
    input  logic [ID_WIDTH-1:0]      fiu_b_id,
    input  logic [1:0]               fiu_b_resp,
    input  logic [USER_WIDTH-1:0]    fiu_b_user,

    output logic                     afu_b_valid,
    input  logic                     afu_b_ready,
    output logic [ID_WIDTH-1:0]      afu_b_id,
    output logic [1:0]               afu_b_resp,
    output logic [USER_WIDTH-1:0]    afu_b_user
);

    localparam int UFLAG_NO_REPLY = 0;
    localparam int REM_WIDTH      = AFU_LEN_WIDTH + 1;
    localparam int PTR_WIDTH      = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
    localparam int CNT_WIDTH      = $clog2(LEN_FIFO_DEPTH + 1);
    localparam logic [REM_WIDTH-1:0]  MAX_BURST_REM = REM_WIDTH'(FIU_MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP     = ADDR_WIDTH'(FIU_MAX_BURST * DATA_BYTES);

    typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [REM_WIDTH-1:0]    rem_q, rem_d;
    logic [REM_WIDTH-1:0]    sub_beats;
    logic                    more_subs;
    logic                    push;

    logic [AFU_LEN_WIDTH-1:0] len_mem_q [LEN_FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]     count_q;
    logic                     fifo_full, fifo_empty, pop;

    logic [AFU_LEN_WIDTH-1:0] beat_q;
    logic [FIU_LEN_WIDTH-1:0] sub_q;
    logic [AFU_LEN_WIDTH-1:0] head_len;
    logic                     w_fire, final_beat, sub_last;
    logic                     noreply;
    logic                     unused_ok;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(LEN_FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign fifo_full  = (count_q == CNT_WIDTH'(LEN_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            user_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            user_q  <= user_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        user_d       = user_q;
        rem_d        = rem_q;
        afu_aw_ready = 1'b0;
        fiu_aw_valid = 1'b0;
        push         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                afu_aw_ready = !fifo_full;
                if (afu_aw_valid && !fifo_full) begin
                    push    = 1'b1;
                    id_d    = afu_aw_id;
                    addr_d  = afu_aw_addr;
                    user_d  = afu_aw_user;
                    rem_d   = REM_WIDTH'(afu_aw_len) + REM_WIDTH'(1);
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                fiu_aw_valid = 1'b1;
                if (fiu_aw_ready) begin
                    if (rem_q <= MAX_BURST_REM) begin
                        state_d = ST_IDLE;
                    end else begin
                        rem_d  = rem_q - MAX_BURST_REM;
                        addr_d = addr_q + ADDR_STEP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every sub-burst except the last is tagged so its B response gets dropped.
    assign more_subs   = (rem_q > MAX_BURST_REM);
    assign sub_beats   = more_subs ? MAX_BURST_REM : rem_q;
    assign fiu_aw_len  = FIU_LEN_WIDTH'(sub_beats - REM_WIDTH'(1));
    assign fiu_aw_id   = id_q;
    assign fiu_aw_addr = addr_q;

    always_comb begin
        fiu_aw_user                 = user_q;
        fiu_aw_user[UFLAG_NO_REPLY] = more_subs;
    end

    assign w_fire     = fiu_w_valid && fiu_w_ready;
    assign head_len   = len_mem_q[rd_ptr_q];
    assign final_beat = (beat_q == head_len);
    assign sub_last   = (sub_q == FIU_LEN_WIDTH'(FIU_MAX_BURST - 1));
    assign pop        = w_fire && final_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LEN_FIFO_DEPTH; i++) begin
                len_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            sub_q    <= '0;
        end else begin
            if (push) begin
                len_mem_q[wr_ptr_q] <= afu_aw_len;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
            if (w_fire) begin
                if (final_beat) begin
                    beat_q <= '0;
                    sub_q  <= '0;
                end else begin
                    beat_q <= beat_q + AFU_LEN_WIDTH'(1);
                    sub_q  <= sub_last ? '0 : sub_q + FIU_LEN_WIDTH'(1);
                end
            end
        end
    end

    // WLAST is regenerated from the recorded length; the AFU's own WLAST is not trusted.
    assign fiu_w_valid = !fifo_empty && afu_w_valid;
    assign afu_w_ready = !fifo_empty && fiu_w_ready;
    assign fiu_w_data  = afu_w_data;
    assign fiu_w_strb  = afu_w_strb;
    assign fiu_w_last  = sub_last || final_beat;
    assign unused_ok   = &{1'b0, afu_w_last};

    assign noreply     = fiu_b_user[UFLAG_NO_REPLY];
    assign afu_b_valid = fiu_b_valid && !noreply;
    assign fiu_b_ready = noreply || afu_b_ready;
    assign afu_b_id    = fiu_b_id;

    always_comb begin
        afu_b_user                 = fiu_b_user;
        afu_b_user[UFLAG_NO_REPLY] = 1'b0;
    end

`ifdef LM_AXI_B_RESP_MERGE_EN
    localparam int IDX_WIDTH = (ID_WIDTH < 4) ? ID_WIDTH : 4;

    logic [1:0]           resp_acc_q [2**IDX_WIDTH];
    logic [IDX_WIDTH-1:0] acc_idx;
    logic [1:0]           merged_resp;

    // Worst response seen so far per ID; relies on in-order same-ID responses.
    assign acc_idx     = fiu_b_id[IDX_WIDTH-1:0];
    assign merged_resp = (resp_acc_q[acc_idx] > fiu_b_resp) ? resp_acc_q[acc_idx] : fiu_b_resp;
    assign afu_b_resp  = merged_resp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**IDX_WIDTH; i++) begin
                resp_acc_q[i] <= '0;
            end
        end else if (fiu_b_valid && noreply) begin
            resp_acc_q[acc_idx] <= merged_resp;
        end else if (afu_b_valid && afu_b_ready) begin
            resp_acc_q[acc_idx] <= '0;
        end
    end
`else
    assign afu_b_resp = fiu_b_resp;
`endif

endmodule
